// File: rtl/bus_mem_responder_pkg.sv
// Shared definitions for the bus memory responder: FSM encoding, debug
// register selects and the latched request record.
package bus_mem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_e;

   localparam logic [5:0] REGSEL_ACC_CNT = 6'b000001;
   localparam logic [5:0] REGSEL_STATUS  = 6'b000010;
   localparam logic [5:0] REGSEL_ADDR    = 6'b000011;

   typedef struct packed {
      logic [7:0] addr;
      logic       oor;
      logic       rw;
      logic [7:0] wdata;
   } req_t;

   function automatic logic addr_out_of_range(input logic [15:0] adr);
      return adr[15:8] != 8'h00;
   endfunction

endpackage

// File: rtl/ram256x8.sv
// 256x8 RAM with synchronous write and registered read. Reset clears the read
// register always, and the array only when CLEAR_ON_RESET is set.
module ram256x8 #(
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       we,
   input  logic       re,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata
);

   logic [7:0] mem [256];
   logic [7:0] rdata_q, rdata_d;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned; a missing default would infer a latch.
   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem[addr];
      end
   end

   // NOTE: the array clears in one edge so the responder is ready on the very
   // next cycle; with CLEAR_ON_RESET=0 reset leaves the contents alone and only
   // blocks the write on that edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         if (CLEAR_ON_RESET) begin
            for (int i = 0; i < 256; i++) begin
               mem[i] <= 8'h00;
            end
         end
      end else if (we) begin
         mem[addr] <= wdata;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= 8'h00;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/bus_mem_responder.sv
// Wait-state bus responder in front of a 256-byte RAM: latches the request,
// counts wait cycles, performs one access and drives read data until released.
module bus_mem_responder
   import bus_mem_responder_pkg::*;
#(
   parameter int unsigned WAIT_STATES   = 2,
   parameter bit          MEM_INIT_ZERO = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] F_adr,
   input  logic        M_RW,
   inout  wire  [15:0] F_data,
   input  logic        DBAP,
   input  logic        NDAP,
   output logic        BUZYSTATE,
   output logic        adr_err,
   input  logic [5:0]  REGSEL,
   output logic [15:0] Debug_reg
);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   req_t       req_q, req_d;
   logic       adr_err_q, adr_err_d;
   logic [7:0] acc_cnt_q, acc_cnt_d;

   logic       ram_we, ram_re;
   logic [7:0] ram_rdata;
   logic [7:0] rd_byte;
   logic       unused_hi;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_d     = req_q;
      adr_err_d = adr_err_q;
      acc_cnt_d = acc_cnt_q;
      ram_we    = 1'b0;
      ram_re    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (DBAP && !NDAP) begin
               state_d       = WAIT;
               cnt_d         = 4'(WAIT_STATES);
               req_d.addr    = F_adr[7:0];
               req_d.oor     = addr_out_of_range(F_adr);
               req_d.rw      = M_RW;
               req_d.wdata   = F_data[7:0];
               if (addr_out_of_range(F_adr)) begin
                  adr_err_d = 1'b1;
               end
            end
         end
         WAIT: begin
            if (NDAP) begin
               state_d = IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = ACCESS;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ACCESS: begin
            // The access itself commits here even if NDAP arrives this cycle.
            acc_cnt_d = acc_cnt_q + 8'd1;
            ram_we    = !req_q.rw && !req_q.oor;
            ram_re    = req_q.rw && !req_q.oor;
            state_d   = NDAP ? IDLE : DONE;
         end
         DONE: begin
            if (NDAP || !DBAP) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         req_q     <= '0;
         adr_err_q <= 1'b0;
         acc_cnt_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         adr_err_q <= adr_err_d;
         acc_cnt_q <= acc_cnt_d;
      end
   end

   ram256x8 #(
      .CLEAR_ON_RESET(MEM_INIT_ZERO)
   ) u_ram (
      .clk  (clk),
      .reset(reset),
      .we   (ram_we),
      .re   (ram_re),
      .addr (req_q.addr),
      .wdata(req_q.wdata),
      .rdata(ram_rdata)
   );

   // Out-of-range reads skip the RAM and return all ones instead.
   assign rd_byte   = req_q.oor ? 8'hFF : ram_rdata;
   assign F_data    = (state_q == DONE && req_q.rw) ? {8'h00, rd_byte} : 16'hzzzz;
   assign BUZYSTATE = (state_q == WAIT) || (state_q == ACCESS);
   assign adr_err   = adr_err_q;
   assign unused_hi = ^F_data[15:8];

   always_comb begin
      Debug_reg = 16'h0000;
      case (REGSEL)
         REGSEL_ACC_CNT: Debug_reg = {8'h00, acc_cnt_q};
         REGSEL_STATUS:  Debug_reg = {12'h000, adr_err_q, state_q, BUZYSTATE};
         REGSEL_ADDR:    Debug_reg = {8'h00, req_q.addr};
         default:        Debug_reg = 16'h0000;
      endcase
   end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Bench for bus_mem_responder: three instances (WAIT_STATES 2/0/3, the last
// without RAM clearing) share one CPU-side driver selected by sel.
module tb_bus_mem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] adr = 16'h0000;
   logic        rw = 1'b0;
   logic        dbap = 1'b0;
   logic        ndap = 1'b0;
   logic [5:0]  regsel = 6'b000000;
   logic        tb_drv = 1'b0;
   logic [15:0] tb_wd = 16'h0000;
   int          sel = 0;

   wire [15:0]  f0, f1, f2;
   wire [2:0]   busy_v, err_v;
   wire [15:0]  dbg0, dbg1, dbg2;
   wire         z0 = (f0 === 16'hzzzz);
   wire         z1 = (f1 === 16'hzzzz);
   wire         z2 = (f2 === 16'hzzzz);

   logic        busy, err, fz;
   logic [15:0] dbg, fbus;

   int n_run  = 0;
   int n_fail = 0;

   logic [7:0] mem_m [3][256];
   logic [7:0] acc_m [3];
   bit         err_m [3];

   always #5 clk = ~clk;

   assign f0 = (tb_drv && sel == 0) ? tb_wd : 16'hzzzz;
   assign f1 = (tb_drv && sel == 1) ? tb_wd : 16'hzzzz;
   assign f2 = (tb_drv && sel == 2) ? tb_wd : 16'hzzzz;

   bus_mem_responder #(.WAIT_STATES(2), .MEM_INIT_ZERO(1'b1)) dut0 (
      .clk(clk), .reset(reset), .F_adr(adr), .M_RW(rw), .F_data(f0),
      .DBAP(dbap && sel == 0), .NDAP(ndap && sel == 0), .BUZYSTATE(busy_v[0]),
      .adr_err(err_v[0]), .REGSEL(regsel), .Debug_reg(dbg0));

   bus_mem_responder #(.WAIT_STATES(0), .MEM_INIT_ZERO(1'b1)) dut1 (
      .clk(clk), .reset(reset), .F_adr(adr), .M_RW(rw), .F_data(f1),
      .DBAP(dbap && sel == 1), .NDAP(ndap && sel == 1), .BUZYSTATE(busy_v[1]),
      .adr_err(err_v[1]), .REGSEL(regsel), .Debug_reg(dbg1));

   bus_mem_responder #(.WAIT_STATES(3), .MEM_INIT_ZERO(1'b0)) dut2 (
      .clk(clk), .reset(reset), .F_adr(adr), .M_RW(rw), .F_data(f2),
      .DBAP(dbap && sel == 2), .NDAP(ndap && sel == 2), .BUZYSTATE(busy_v[2]),
      .adr_err(err_v[2]), .REGSEL(regsel), .Debug_reg(dbg2));

   always_comb begin
      busy = busy_v[0]; err = err_v[0]; dbg = dbg0; fbus = f0; fz = z0;
      case (sel)
         1: begin busy = busy_v[1]; err = err_v[1]; dbg = dbg1; fbus = f1; fz = z1; end
         2: begin busy = busy_v[2]; err = err_v[2]; dbg = dbg2; fbus = f2; fz = z2; end
         default: ;
      endcase
   end

   function automatic int ws_of(input int k);
      case (k)
         0: return 2;
         1: return 0;
         default: return 3;
      endcase
   endfunction

   function automatic bit miz_of(input int k);
      return k != 2;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Transaction-level reference: one completed access per call.
   task automatic model_access(input int k, input bit is_rd, input logic [15:0] a,
                               input logic [7:0] wd, output logic [15:0] rd);
      acc_m[k] = acc_m[k] + 8'd1;
      rd = 16'h0000;
      if (a[15:8] != 8'h00) begin
         err_m[k] = 1'b1;
         rd = 16'h00FF;
      end else if (is_rd) begin
         rd = {8'h00, mem_m[k][a[7:0]]};
      end else begin
         mem_m[k][a[7:0]] = wd;
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         acc_m[k] = 8'h00;
         err_m[k] = 1'b0;
         if (miz_of(k)) begin
            for (int i = 0; i < 256; i++) mem_m[k][i] = 8'h00;
         end
      end
   endtask

   task automatic do_access(input int k, input bit is_rd, input logic [15:0] a,
                            input logic [7:0] wd, input string tag, input bit disturb,
                            output logic [15:0] got);
      logic [15:0] exp_rd;
      int lat;
      sel = k; adr = a; rw = is_rd; tb_wd = {8'h00, wd}; tb_drv = !is_rd; dbap = 1'b1;
      @(negedge clk);
      tb_drv = disturb;
      if (disturb) begin
         adr = a ^ 16'h0003; rw = !is_rd; tb_wd = ~tb_wd;
      end
      lat = 1;
      while (busy && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      tb_drv = 1'b0;
      model_access(k, is_rd, a, wd, exp_rd);
      check({tag, " latency"}, 16'(lat), 16'(ws_of(k) + 3));
      regsel = 6'b000010;
      #1;
      got = fbus;
      if (is_rd) check({tag, " rdata"}, fbus, exp_rd);
      else check({tag, " bus released"}, {15'd0, fz}, 16'd1);
      check({tag, " status done"}, dbg, {12'h000, err_m[k], 2'd3, 1'b0});
      regsel = 6'b000001;
      #1;
      check({tag, " acc_cnt"}, dbg, {8'h00, acc_m[k]});
      regsel = 6'b000011;
      #1;
      check({tag, " addr"}, dbg, {8'h00, a[7:0]});
      dbap = 1'b0;
      @(negedge clk);
      regsel = 6'b000010;
      #1;
      check({tag, " idle gap"}, dbg, {12'h000, err_m[k], 2'd0, 1'b0});
   endtask

   task automatic wait_state(input logic [1:0] st, input string tag);
      int n = 0;
      regsel = 6'b000010;
      #1;
      while (dbg[2:1] != st && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      check({tag, " reached state"}, {14'd0, dbg[2:1]}, {14'd0, st});
   endtask

   task automatic start_write(input int k, input logic [15:0] a, input logic [7:0] wd);
      sel = k; adr = a; rw = 1'b0; tb_wd = {8'h00, wd}; tb_drv = 1'b1; dbap = 1'b1;
      @(negedge clk);
      tb_drv = 1'b0;
   endtask

   typedef struct {
      bit          rd;
      logic [15:0] adr;
      logic [7:0]  wd;
      logic [15:0] exp_rd;
      bit          exp_err;
   } vec_t;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs [9];
      logic [15:0] got, dummy;

      vecs[0] = '{1'b0, 16'h0010, 8'hA5, 16'h0000, 1'b0};
      vecs[1] = '{1'b1, 16'h0010, 8'h00, 16'h00A5, 1'b0};
      vecs[2] = '{1'b0, 16'h00FF, 8'h5A, 16'h0000, 1'b0};
      vecs[3] = '{1'b1, 16'h00FF, 8'h00, 16'h005A, 1'b0};
      vecs[4] = '{1'b1, 16'h0000, 8'h00, 16'h0000, 1'b0};
      vecs[5] = '{1'b0, 16'h0110, 8'h11, 16'h0000, 1'b1};
      vecs[6] = '{1'b1, 16'h0010, 8'h00, 16'h00A5, 1'b1};
      vecs[7] = '{1'b1, 16'h0110, 8'h00, 16'h00FF, 1'b1};
      vecs[8] = '{1'b1, 16'hFF00, 8'h00, 16'h00FF, 1'b1};

      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      model_reset();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         sel = k;
         regsel = 6'b000001;
         #1;
         check($sformatf("reset%0d busy", k), {15'd0, busy}, 16'd0);
         check($sformatf("reset%0d bus z", k), {15'd0, fz}, 16'd1);
         check($sformatf("reset%0d adr_err", k), {15'd0, err}, 16'd0);
         check($sformatf("reset%0d acc_cnt", k), dbg, 16'h0000);
         regsel = 6'b000010;
         #1;
         check($sformatf("reset%0d status", k), dbg, 16'h0000);
      end
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         do_access(0, vecs[i].rd, vecs[i].adr, vecs[i].wd, $sformatf("vec%0d", i), 1'b0, got);
         if (vecs[i].rd) check($sformatf("vec%0d table rdata", i), got, vecs[i].exp_rd);
         check($sformatf("vec%0d table adr_err", i), {15'd0, err}, {15'd0, vecs[i].exp_err});
         if (i == 1) begin
            regsel = 6'b000001;
            #1;
            check("wr-rd acc_cnt", dbg, 16'h0002);
         end
         @(negedge clk);
      end

      // Abort in the first WAIT cycle: no write, no access counted.
      start_write(0, 16'h0020, 8'h3C);
      regsel = 6'b000010;
      #1;
      check("abort in wait", {14'd0, dbg[2:1]}, 16'd1);
      ndap = 1'b1; dbap = 1'b0;
      @(negedge clk);
      ndap = 1'b0;
      #1;
      check("abort to idle", dbg, {12'h000, err_m[0], 2'd0, 1'b0});
      regsel = 6'b000001;
      #1;
      check("abort acc_cnt", dbg, {8'h00, acc_m[0]});
      @(negedge clk);
      do_access(0, 1'b1, 16'h0020, 8'h00, "abort rd", 1'b0, got);
      check("abort no write", got, 16'h0000);

      // Bus changes during WAIT must not affect the latched request.
      do_access(0, 1'b0, 16'h0005, 8'h77, "stable wr", 1'b1, got);
      do_access(0, 1'b1, 16'h0005, 8'h00, "stable rd5", 1'b0, got);
      check("stable byte", got, 16'h0077);
      do_access(0, 1'b1, 16'h0006, 8'h00, "stable rd6", 1'b0, got);
      check("stable neighbour", got, 16'h0000);

      // NDAP in ACCESS: write stays committed.
      start_write(2, 16'h0040, 8'h66);
      wait_state(2'd2, "ndap access");
      ndap = 1'b1; dbap = 1'b0;
      @(negedge clk);
      ndap = 1'b0;
      model_access(2, 1'b0, 16'h0040, 8'h66, dummy);
      #1;
      check("ndap access idle", dbg, {12'h000, err_m[2], 2'd0, 1'b0});
      @(negedge clk);
      do_access(2, 1'b1, 16'h0040, 8'h00, "ndap access rd", 1'b0, got);
      check("ndap access kept", got, 16'h0066);

      // Reset in ACCESS on the non-clearing instance: old byte survives.
      do_access(2, 1'b0, 16'h0030, 8'h44, "rst pre wr", 1'b0, got);
      start_write(2, 16'h0030, 8'h99);
      wait_state(2'd2, "rst access");
      reset = 1'b1; dbap = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      regsel = 6'b000001;
      #1;
      check("rst busy", {15'd0, busy}, 16'd0);
      check("rst bus z", {15'd0, fz}, 16'd1);
      check("rst acc_cnt", dbg, 16'h0000);
      check("rst adr_err inst0", {15'd0, err_v[0]}, {15'd0, err_m[0]});
      check("rst adr_err", {15'd0, err}, 16'd0);
      @(negedge clk);
      do_access(2, 1'b1, 16'h0030, 8'h00, "rst rd", 1'b0, got);
      check("rst no write", got, 16'h0044);
      do_access(0, 1'b1, 16'h0010, 8'h00, "clear rd", 1'b0, got);
      check("clear by reset", got, 16'h0000);

      for (int i = 0; i < 200; i++) begin
         logic [15:0] a;
         a = ($urandom_range(0, 9) == 0) ? 16'($urandom) : {8'h00, 8'($urandom_range(0, 31))};
         do_access(1, 1'($urandom), a, 8'($urandom), $sformatf("rnd%0d", i),
                   ($urandom_range(0, 3) == 0), got);
      end

      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      for (int i = 0; i < 256; i++) begin
         do_access(1, 1'b1, {8'h00, 8'($urandom)}, 8'h00, $sformatf("wrap%0d", i), 1'b0, got);
      end
      sel = 1;
      regsel = 6'b000001;
      #1;
      check("acc_cnt wrap", dbg, 16'h0000);

      sel = 0;
      regsel = 6'b000000;
      #1;
      check("regsel 0", dbg, 16'h0000);
      regsel = 6'b000100;
      #1;
      check("regsel 4", dbg, 16'h0000);
      regsel = 6'b100011;
      #1;
      check("regsel 35", dbg, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
